// File: rtl/rca_bist.sv
`timescale 1ns/1ps
// Self-test driver/checker for the 4-bit ripple-carry adder rc1.
// Define RCA_BIST_FAIL_CAPTURE_EN to latch the first failing vector on fail_vec.
module rca_bist #(
    parameter int         NUM_VECTORS = 128,
    parameter logic [8:0] SEED        = 9'h1FF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    output logic [3:0]  a,
    output logic [3:0]  b,
    output logic        cin,
    input  logic [4:0]  s,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [7:0]  err_count,
    output logic [7:0]  vec_count,
    output logic [13:0] fail_vec
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [8:0] LOAD = (SEED == 9'h000) ? 9'h001 : SEED;
    localparam logic [7:0] LAST = 8'(NUM_VECTORS - 1);

    state_t     state;
    logic [8:0] lfsr;
    logic [4:0] exp_sum;
    logic       mismatch;
    logic       launch;
    logic [7:0] err_next;

    // Operands come straight from flops so the adder sees no glitches.
    assign a   = lfsr[3:0];
    assign b   = lfsr[7:4];
    assign cin = lfsr[8];

    assign mismatch = (s != exp_sum);
    assign launch   = start && (state == S_IDLE || state == S_DONE);
    assign err_next = (mismatch && err_count != 8'hFF)
                      ? err_count + 8'd1 : err_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IDLE;
            lfsr      <= 9'h000;
            exp_sum   <= 5'h00;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 8'h00;
            vec_count <= 8'h00;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        lfsr      <= LOAD;
                        err_count <= 8'h00;
                        vec_count <= 8'h00;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        state     <= S_DRIVE;
                    end
                end
                S_DRIVE: begin
                    exp_sum <= {1'b0, a} + {1'b0, b} + {4'b0000, cin};
                    state   <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    err_count <= err_next;
                    vec_count <= vec_count + 8'd1;
                    lfsr      <= {lfsr[7:0], lfsr[8] ^ lfsr[4]};
                    if (vec_count == LAST) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (err_next == 8'h00);
                        state <= S_DONE;
                    end else begin
                        state <= S_DRIVE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef RCA_BIST_FAIL_CAPTURE_EN
    logic [13:0] fail_q;

    // err_count still zero means this is the first miss of the run.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fail_q <= 14'h0000;
        end else if (launch) begin
            fail_q <= 14'h0000;
        end else if (state == S_SAMPLE && mismatch && err_count == 8'h00) begin
            fail_q <= {a, b, cin, s};
        end
    end

    assign fail_vec = fail_q;
`else
    logic unused_launch;
    assign unused_launch = launch;
    assign fail_vec      = 14'h0000;
`endif

endmodule

// File: tb/tb_rca_bist.sv
`timescale 1ns/1ps
// Bench for rca_bist: modelled adders in loopback, table of runs, corner sequences.
module tb_rca_bist;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [3:0]  a, b;
    logic        cin;
    logic [4:0]  s;
    logic        busy, done, pass;
    logic [7:0]  err_count, vec_count;
    logic [13:0] fail_vec;

    logic        start2;
    logic [3:0]  a2, b2;
    logic        cin2;
    logic [4:0]  s2;
    logic        busy2, done2, pass2;
    logic [7:0]  err2, vec2;
    logic [13:0] fail2;

    int          mode;
    logic [3:0]  fa;
    logic [4:0]  fm;

    int asserts = 0;
    int fails   = 0;

    always #5 clk = ~clk;

    rca_bist dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .a(a), .b(b), .cin(cin), .s(s),
        .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .vec_count(vec_count),
        .fail_vec(fail_vec)
    );

    rca_bist #(.NUM_VECTORS(4), .SEED(9'h000)) dut2 (
        .clk(clk), .reset_n(reset_n), .start(start2),
        .a(a2), .b(b2), .cin(cin2), .s(s2),
        .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .vec_count(vec2),
        .fail_vec(fail2)
    );

    // Adder models: 0 good, 1 stuck zero, 2 drops carry-in, 3 random fault.
    function automatic logic [4:0] adder(input int md, input logic [3:0] x,
                                         input logic [3:0] y, input logic c,
                                         input logic [3:0] fx, input logic [4:0] fmk);
        int sum;
        sum = int'(x) + int'(y) + int'(c);
        case (md)
            0:       return 5'(sum);
            1:       return 5'h00;
            2:       return 5'(int'(x) + int'(y));
            default: return 5'(sum) ^ ((x == fx) ? fmk : 5'h00);
        endcase
    endfunction

    always_comb s  = adder(mode, a, b, cin, fa, fm);
    always_comb s2 = adder(0, a2, b2, cin2, 4'h0, 5'h00);

    // Reference: walk the 128 default-seed vectors with integer arithmetic.
    function automatic void ref_run(input int md, input logic [3:0] fx,
                                    input logic [4:0] fmk, output int errs,
                                    output logic [13:0] first);
        int st;
        int x, y, c, want;
        logic [4:0] got;
        st = 'h1FF;
        errs = 0;
        first = '0;
        for (int k = 0; k < 128; k++) begin
            x = st % 16;
            y = (st / 16) % 16;
            c = (st / 256) % 2;
            want = x + y + c;
            got = adder(md, 4'(x), 4'(y), 1'(c), fx, fmk);
            if (int'(got) != want) begin
                if (errs == 0) first = {4'(x), 4'(y), 1'(c), got};
                errs++;
            end
            st = ((st * 2) % 512) + (((st / 256) + (st / 16)) % 2);
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        asserts++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, want);
        end
    endtask

    typedef struct {
        int          mode;
        logic [3:0]  fa;
        logic [4:0]  fm;
        int          restart_at;
        int          exp_err;
        logic        exp_pass;
        logic [13:0] exp_fv;
    } vec_t;

    vec_t tbl[8];

    task automatic run_vec(input vec_t v, input string tag);
        int edges;
        logic busy_bad;
        logic [13:0] want_fv;
        mode = v.mode;
        fa = v.fa;
        fm = v.fm;
        busy_bad = 1'b0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        edges = 0;
        chk({tag, " busy_after_start"}, 32'(busy), 32'd1);
        chk({tag, " counts_cleared"}, {16'h0, err_count, vec_count}, 32'h0);
        chk({tag, " first_vector"}, {23'h0, a, b, cin}, {23'h0, 4'hF, 4'hF, 1'b1});
        while (!done && edges < 1000) begin
            @(negedge clk);
            edges++;
            start = (edges == v.restart_at);
            if (edges == 2)
                chk({tag, " second_vector"}, {23'h0, a, b, cin}, {23'h0, 4'hE, 4'hF, 1'b1});
            if (edges == v.restart_at + 2)
                chk({tag, " restart_ignored_count"}, 32'(vec_count), 32'((v.restart_at + 2) / 2));
            if (!done && !busy) busy_bad = 1'b1;
        end
        start = 1'b0;
        chk({tag, " done_edge"}, 32'(edges), 32'd256);
        chk({tag, " busy_through_run"}, 32'(busy_bad), 32'd0);
        chk({tag, " err_count"}, 32'(err_count), 32'(v.exp_err));
        chk({tag, " pass"}, 32'(pass), 32'(v.exp_pass));
        chk({tag, " vec_count"}, 32'(vec_count), 32'd128);
        chk({tag, " busy_done"}, 32'(busy), 32'd0);
`ifdef RCA_BIST_FAIL_CAPTURE_EN
        want_fv = v.exp_fv;
`else
        want_fv = 14'h0;
`endif
        chk({tag, " fail_vec"}, 32'(fail_vec), 32'(want_fv));
        repeat (3) @(negedge clk);
        chk({tag, " hold_in_done"}, {14'h0, done, pass, err_count, vec_count},
            {14'h0, 1'b1, v.exp_pass, 8'(v.exp_err), 8'd128});
    endtask

    initial begin
        int e;
        logic [13:0] f;
        int edges;

        tbl[0] = '{0, 4'h0, 5'h00, -10, 0, 1'b1, 14'h0};
        tbl[1] = '{1, 4'h0, 5'h00, -10, 128, 1'b0, {4'hF, 4'hF, 1'b1, 5'h00}};
        ref_run(2, 4'h0, 5'h00, e, f);
        tbl[2] = '{2, 4'h0, 5'h00, -10, e, e == 0, {4'hF, 4'hF, 1'b1, 5'h1E}};
        tbl[3] = '{0, 4'h0, 5'h00, 50, 0, 1'b1, 14'h0};
        for (int i = 4; i < 7; i++) begin
            tbl[i].mode = 3;
            tbl[i].fa = 4'($urandom_range(0, 15));
            tbl[i].fm = 5'($urandom_range(1, 31));
            tbl[i].restart_at = -10;
            ref_run(3, tbl[i].fa, tbl[i].fm, e, f);
            tbl[i].exp_err = e;
            tbl[i].exp_pass = (e == 0);
            tbl[i].exp_fv = f;
        end
        tbl[7] = '{0, 4'h0, 5'h00, -10, 0, 1'b1, 14'h0};

        mode = 0; fa = 0; fm = 0;
        start = 1'b0;
        start2 = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_outputs", {a, b, cin, busy, done, pass, 14'h0}, 32'h0);
        chk("reset_counts", {err_count, vec_count, 2'b0, fail_vec}, 32'h0);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_no_start", {29'h0, busy, done, pass}, 32'h0);

        for (int i = 0; i < 8; i++) run_vec(tbl[i], $sformatf("run%0d", i));

        // Reset in the middle of a run.
        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("midrun_reset_outputs", {a, b, cin, busy, done, pass, 14'h0}, 32'h0);
        chk("midrun_reset_counts", {err_count, vec_count, 2'b0, fail_vec}, 32'h0);
        @(negedge clk) reset_n = 1'b1;
        run_vec(tbl[0], "after_reset");

        // Small instance: zero seed, four vectors.
        @(negedge clk) start2 = 1'b1;
        @(negedge clk) start2 = 1'b0;
        chk("seed0_first_vector", {23'h0, a2, b2, cin2}, {23'h0, 4'h1, 4'h0, 1'b0});
        edges = 0;
        while (!done2 && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        chk("seed0_done_edge", 32'(edges), 32'd8);
        chk("seed0_result", {15'h0, pass2, err2, vec2}, {15'h0, 1'b1, 8'd0, 8'd4});

        $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
        $finish;
    end

endmodule
